// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Measures an incoming PWM waveform and reports its frequency in Hz and its
// high time in microseconds. The output encoding matches the PWM generator's
// freq / duty_cycle_usec inputs, so a generator-to-capture loopback reads back
// the generator's own settings.
//
// Optional build macro: PWM_CAPTURE_GLITCH_FILTER_EN
//   Defined   : a 3-sample hold filter follows the synchronizer. Pulses of
//               2 clocks or less are ignored, and edges are seen 3 clocks later.
//   Undefined : the synchronizer feeds the edge detector directly.
//
// Ports:
//   clk             in   main clock (CLK_FREQUENCY Hz)
//   rst_n           in   asynchronous active-low reset
//   pin             in   asynchronous PWM input
//   freq            out  measured frequency in Hz, saturating at 65535
//   duty_cycle_usec out  measured high time in usec, saturating at 65535
//   valid           out  one-cycle pulse; freq/duty_cycle_usec updated this cycle
//   overrun         out  sticky; a period ended while the divider was busy
//   no_signal       out  high while the input is timed out
// ---------------------------------------------------------------------------
module pwm_capture #(
  parameter int CLK_FREQUENCY  = 25000000,
  parameter int CYCLES_IN_USEC = 25,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pin,
  output logic [15:0] freq,
  output logic [15:0] duty_cycle_usec,
  output logic        valid,
  output logic        overrun,
  output logic        no_signal
);

  localparam int CW = 26;
  localparam int PW = (CYCLES_IN_USEC > 1) ? $clog2(CYCLES_IN_USEC) : 1;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] DIVIDEND    = CW'(CLK_FREQUENCY);
  localparam logic [PW-1:0] PRE_MAX     = PW'(CYCLES_IN_USEC - 1);
  localparam logic [4:0]    LAST_BIT    = 5'(CW - 1);

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  logic level;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  // The filtered level only moves once the current and two previous
  // synchronized samples agree; anything shorter is held off.
  logic [1:0] hist;
  logic       filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b00;
      filt <= 1'b0;
    end else begin
      hist <= {hist[0], sync2};
      if (sync2 && hist[0] && hist[1]) begin
        filt <= 1'b1;
      end else if (!sync2 && !hist[0] && !hist[1]) begin
        filt <= 1'b0;
      end
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  // level_q is aligned with rise; level_qq lags one more clock so the first
  // high clock of a period is sampled after the counters have restarted.
  logic level_q, level_qq, rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= 1'b0;
      level_qq <= 1'b0;
      rise     <= 1'b0;
    end else begin
      level_q  <= level;
      level_qq <= level_q;
      rise     <= level & ~level_q;
    end
  end

  // -------------------------------------------------------------------------
  // Period / high-time counters, restarted on every detected rise
  // -------------------------------------------------------------------------
  logic [CW-1:0] period_cnt;
  logic [PW-1:0] usec_pre;
  logic [16:0]   high_usec;
  logic          pre_wrap;
  logic          timed_out;

  assign pre_wrap  = (usec_pre == PRE_MAX);
  assign timed_out = (period_cnt == TIMEOUT_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      usec_pre   <= '0;
      high_usec  <= '0;
    end else if (rise) begin
      period_cnt <= CW'(1);
      usec_pre   <= '0;
      high_usec  <= '0;
    end else begin
      if (period_cnt < TIMEOUT_VAL) begin
        period_cnt <= period_cnt + CW'(1);
      end
      usec_pre <= pre_wrap ? '0 : usec_pre + PW'(1);
      if (pre_wrap && level_qq && (high_usec != '1)) begin
        high_usec <= high_usec + 17'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Restoring divider datapath: CLK_FREQUENCY / divisor, MSB first
  // -------------------------------------------------------------------------
  logic [CW-1:0] divisor, remainder, quotient, dividend_sr;
  logic [16:0]   duty_latch;
  logic [4:0]    bit_cnt;
  logic [CW:0]   trial;
  logic          take;
  logic [CW-1:0] rem_next, quo_next;

  always_comb begin
    trial    = {remainder, dividend_sr[CW-1]};
    take     = (trial >= {1'b0, divisor});
    rem_next = take ? CW'(trial - {1'b0, divisor}) : trial[CW-1:0];
    quo_next = {quotient[CW-2:0], take};
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {ARM, MEASURE, DIVIDE} state_t;
  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ARM;
      freq            <= '0;
      duty_cycle_usec <= '0;
      valid           <= 1'b0;
      overrun         <= 1'b0;
      no_signal       <= 1'b0;
      divisor         <= '0;
      remainder       <= '0;
      quotient        <= '0;
      dividend_sr     <= '0;
      duty_latch      <= '0;
      bit_cnt         <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ARM: begin
          // First rise only starts the counters; there is no full period yet.
          if (rise) begin
            state <= MEASURE;
          end else if (timed_out && !no_signal) begin
            valid           <= 1'b1;
            freq            <= '0;
            duty_cycle_usec <= '0;
            no_signal       <= 1'b1;
          end
        end

        MEASURE: begin
          // A rise on the timeout clock wins and is measured normally.
          if (rise) begin
            divisor     <= period_cnt;
            duty_latch  <= high_usec;
            remainder   <= '0;
            quotient    <= '0;
            dividend_sr <= DIVIDEND;
            bit_cnt     <= '0;
            state       <= DIVIDE;
          end else if (timed_out) begin
            state <= ARM;
            if (!no_signal) begin
              valid           <= 1'b1;
              freq            <= '0;
              duty_cycle_usec <= '0;
              no_signal       <= 1'b1;
            end
          end
        end

        DIVIDE: begin
          // A period that ends here is dropped; the counters still restart.
          if (rise) begin
            overrun <= 1'b1;
          end
          remainder   <= rem_next;
          quotient    <= quo_next;
          dividend_sr <= dividend_sr << 1;
          bit_cnt     <= bit_cnt + 5'd1;
          if (bit_cnt == LAST_BIT) begin
            freq            <= (|quo_next[CW-1:16]) ? 16'hFFFF : quo_next[15:0];
            duty_cycle_usec <= duty_latch[16] ? 16'hFFFF : duty_latch[15:0];
            valid           <= 1'b1;
            no_signal       <= 1'b0;
            state           <= MEASURE;
          end
        end

        default: state <= ARM;
      endcase
    end
  end

endmodule
